sid_player: RTL and testbench

Parametrised command sequencer that replays a stored stream of SID register writes into up to NUM_SIDS SID cores. It also generates the shared 1 MHz SID clock-enable and sequences the SID and DAC resets. It sits between a registered command ROM and the sid8580 instances, and supersedes the single-SID fixed-divider player logic. New over that logic: multi-SID select, run/stop control, an explicit END command with optional looping, and status outputs.

---
 rtl/sid_player_pkg.sv | 25 ++
 rtl/sid_player_if.sv | 38 +++
 rtl/sid_tick_gen.sv | 39 +++
 rtl/sid_player.sv | 178 +++++++++++++++++
 tb/tb_sid_player.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_player_pkg.sv
// sid_player_pkg: command codes, FSM state encoding and command word field widths shared by
// the SID player, its bus interface and the testbench.
package sid_player_pkg;

   // Command word fields: {sel, reg_addr, reg_data}; sel width is a per-instance parameter.
   localparam int unsigned RegAddrW = 5;
   localparam int unsigned RegDataW = 8;

   // Reserved register addresses reused as sequencer commands.
   localparam logic [RegAddrW-1:0] CMD_DELAY = 5'h1F;
   localparam logic [RegAddrW-1:0] CMD_END   = 5'h1E;

   typedef enum logic [1:0] {
      StRst  = 2'd0,
      StIdle = 2'd1,
      StPlay = 2'd2,
      StHalt = 2'd3
   } state_e;

   // Addresses below the command codes are genuine SID register writes.
   function automatic logic is_reg_write(input logic [RegAddrW-1:0] addr);
      return addr < CMD_END;
   endfunction

endpackage

// File: rtl/sid_player_if.sv
// sid_player_if: run control, command ROM port, SID write bus and status of the SID player.
// master = player side, slave = ROM/SID/board side.
interface sid_player_if
   import sid_player_pkg::*;
#(
   parameter int unsigned ROM_AW   = 8,
   parameter int unsigned NUM_SIDS = 2,
   parameter int unsigned SEL_W    = 2
) ();

   logic                run;
   logic [ROM_AW-1:0]   rom_index;
   logic                rom_read_en;
   logic [SEL_W-1:0]    rom_sel;
   logic [RegAddrW-1:0] rom_addr;
   logic [RegDataW-1:0] rom_data;
   logic                sid_ce_1m;
   logic [NUM_SIDS-1:0] sid_we;
   logic [RegAddrW-1:0] sid_addr;
   logic [RegDataW-1:0] sid_data;
   logic                sid_reset;
   logic                dac_reset;
   logic                playing;
   logic                halted;

   modport master (
      input  run, rom_sel, rom_addr, rom_data,
      output rom_index, rom_read_en, sid_ce_1m, sid_we, sid_addr, sid_data,
             sid_reset, dac_reset, playing, halted
   );

   modport slave (
      output run, rom_sel, rom_addr, rom_data,
      input  rom_index, rom_read_en, sid_ce_1m, sid_we, sid_addr, sid_data,
             sid_reset, dac_reset, playing, halted
   );

endinterface

// File: rtl/sid_tick_gen.sv
// sid_tick_gen: free-running down-counter from CLK_DIV-1 to 0 producing the phase within a SID
// tick and a registered one-clk enable that is high on the clk after phase 0.
module sid_tick_gen #(
   parameter int unsigned CLK_DIV = 12
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   output logic [$clog2(CLK_DIV)-1:0] phase_o,
   output logic                       ce_o
);

   localparam int unsigned PhaseW = $clog2(CLK_DIV);

   logic [PhaseW-1:0] phase_q, phase_d;
   logic              ce_q;

   // Next phase: count down, reload at zero.
   always_comb begin
      phase_d = phase_q - 1'b1;
      if (phase_q == '0) begin
         phase_d = PhaseW'(CLK_DIV - 1);
      end
   end

   // Phase and enable registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q <= PhaseW'(CLK_DIV - 1);
         ce_q    <= 1'b0;
      end else begin
         phase_q <= phase_d;
         ce_q    <= (phase_q == '0);
      end
   end

   assign phase_o = phase_q;
   assign ce_o    = ce_q;

endmodule

// File: rtl/sid_player.sv
// sid_player: replays a command ROM of SID register writes into NUM_SIDS SID cores, one command
// per SID tick, and sequences the SID and DAC resets.
// Build option: define SID_PLAYER_LOOP_EN to make END restart at LOOP_ADDR instead of halting.
module sid_player
   import sid_player_pkg::*;
#(
   parameter int unsigned CLK_DIV       = 12,
   parameter int unsigned ROM_AW        = 8,
   parameter int unsigned NUM_SIDS      = 2,
   parameter int unsigned SEL_W         = 2,
   parameter int unsigned DAC_RST_TICKS = 3,
   parameter int unsigned LOOP_ADDR     = 0
) (
   input logic          clk_i,
   input logic          rst_i,
   sid_player_if.master bus_io
);

   localparam int unsigned PhaseW = $clog2(CLK_DIV);
   localparam int unsigned DacW   = $clog2(DAC_RST_TICKS + 1) + 1;

`ifdef SID_PLAYER_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   localparam logic [PhaseW-1:0] PhStart = PhaseW'(CLK_DIV - 1);
   localparam logic [PhaseW-1:0] PhDec   = PhaseW'(CLK_DIV - 2);
   localparam logic [ROM_AW-1:0] LoopIdx = ROM_AW'(LOOP_ADDR);

   logic [PhaseW-1:0] phase;
   logic              ce;
   logic              tick_start, tick_dec, tick_end;
   logic              fetch;
   logic [SEL_W-1:0]  sel;

   state_e              state_q, state_d;
   logic [ROM_AW-1:0]   index_q, index_d;
   logic [RegDataW-1:0] wait_q, wait_d;
   logic                fetched_q, fetched_d;
   logic                end_q, end_d;
   logic [NUM_SIDS-1:0] sid_we_q, sid_we_d;
   logic [RegAddrW-1:0] sid_addr_q, sid_addr_d;
   logic [RegDataW-1:0] sid_data_q, sid_data_d;
   logic [DacW-1:0]     dac_cnt_q, dac_cnt_d;
   logic                sid_reset_q, dac_reset_q, playing_q, halted_q;

   sid_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .phase_o (phase),
      .ce_o    (ce)
   );

   assign tick_start = (phase == PhStart);
   assign tick_dec   = (phase == PhDec);
   assign tick_end   = (phase == '0);
   assign sel        = bus_io.rom_sel;

   // Fetch is only issued at the start of a tick with no pending delay.
   assign fetch = (state_q == StPlay) && (wait_q == '0) && bus_io.run && tick_start;

   // Sequencer state: reset release, run/pause and END handling.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRst: begin
            if (tick_end) state_d = StIdle;
         end
         StIdle: begin
            if (tick_start && bus_io.run) state_d = StPlay;
         end
         StPlay: begin
            if (tick_start && !bus_io.run) begin
               state_d = StIdle;
            end else if (!LoopEn && tick_dec && fetched_q && (bus_io.rom_addr == CMD_END)) begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
      endcase
   end

   // Command datapath: fetch tracking, decode, write strobes, index and delay counters.
   always_comb begin
      index_d    = index_q;
      wait_d     = wait_q;
      fetched_d  = fetched_q;
      end_d      = end_q;
      sid_we_d   = sid_we_q;
      sid_addr_d = sid_addr_q;
      sid_data_d = sid_data_q;
      dac_cnt_d  = dac_cnt_q;

      if (fetch) fetched_d = 1'b1;

      // Strobes stay up through the SID enable clk, then drop.
      if (tick_start) sid_we_d = '0;

      // ROM data is valid on the clk after the read strobe.
      if (tick_dec && fetched_q) begin
         if (bus_io.rom_addr == CMD_DELAY) begin
            wait_d = bus_io.rom_data;
         end else if (bus_io.rom_addr == CMD_END) begin
            end_d = 1'b1;
         end else if (is_reg_write(bus_io.rom_addr) && (32'(sel) < NUM_SIDS)) begin
            sid_addr_d = bus_io.rom_addr;
            sid_data_d = bus_io.rom_data;
            for (int unsigned i = 0; i < NUM_SIDS; i++) begin
               sid_we_d[i] = (32'(sel) == i);
            end
         end
      end

      if (tick_end) begin
         fetched_d = 1'b0;
         end_d     = 1'b0;
         if (fetched_q) begin
            // A halted END keeps pointing at itself.
            if (end_q) index_d = LoopEn ? LoopIdx : index_q;
            else       index_d = index_q + 1'b1;
         end else if ((state_q == StPlay) && (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
         end
         if (dac_cnt_q != '0) dac_cnt_d = dac_cnt_q - 1'b1;
      end
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StRst;
         index_q     <= '0;
         wait_q      <= '0;
         fetched_q   <= 1'b0;
         end_q       <= 1'b0;
         sid_we_q    <= '0;
         sid_addr_q  <= '0;
         sid_data_q  <= '0;
         dac_cnt_q   <= DacW'(DAC_RST_TICKS);
         sid_reset_q <= 1'b1;
         dac_reset_q <= 1'b1;
         playing_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         wait_q      <= wait_d;
         fetched_q   <= fetched_d;
         end_q       <= end_d;
         sid_we_q    <= sid_we_d;
         sid_addr_q  <= sid_addr_d;
         sid_data_q  <= sid_data_d;
         dac_cnt_q   <= dac_cnt_d;
         sid_reset_q <= (state_d == StRst);
         dac_reset_q <= (dac_cnt_d != '0);
         playing_q   <= (state_q == StPlay);
         halted_q    <= (state_q == StHalt);
      end
   end

   assign bus_io.rom_index   = index_q;
   assign bus_io.rom_read_en = fetch;
   assign bus_io.sid_ce_1m   = ce;
   assign bus_io.sid_we      = sid_we_q;
   assign bus_io.sid_addr    = sid_addr_q;
   assign bus_io.sid_data    = sid_data_q;
   assign bus_io.sid_reset   = sid_reset_q;
   assign bus_io.dac_reset   = dac_reset_q;
   assign bus_io.playing     = playing_q;
   assign bus_io.halted      = halted_q;

endmodule

// File: tb/tb_sid_player.sv
// tb_sid_player: directed tests of the SID player with CLK_DIV = 12, NUM_SIDS = 2 and a
// registered behavioural command ROM. Cycle k counts negedges after reset release; the tick
// starts (phase 11) at k = 0, 12, 24, ...
module tb_sid_player;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   cyc;

   logic [14:0] rom_mem [0:255];

   sid_player_if #(
      .ROM_AW   (8),
      .NUM_SIDS (2),
      .SEL_W    (2)
   ) bus ();

   sid_player #(
      .CLK_DIV       (12),
      .ROM_AW        (8),
      .NUM_SIDS      (2),
      .SEL_W         (2),
      .DAC_RST_TICKS (3),
      .LOOP_ADDR     (0)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Registered ROM: word = {sel[1:0], addr[4:0], data[7:0]}.
   always @(posedge clk) begin
      if (bus.rom_read_en) begin
         {bus.rom_sel, bus.rom_addr, bus.rom_data} <= rom_mem[bus.rom_index];
      end
   end

   // Fill with DELAY 0 (one-tick no-op).
   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom_mem[i] = {2'd0, 5'h1F, 8'h00};
   endtask

   task automatic do_reset();
      bus.run = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      bus.run = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.sid_reset !== 1'b1 || bus.dac_reset !== 1'b1) begin
         $display("FAIL reset_rst_outs: got sid_reset=%b dac_reset=%b expected 1 1",
                  bus.sid_reset, bus.dac_reset);
         n_fail++;
      end
      n_checks++;
      if (bus.sid_we !== 2'b00 || bus.sid_addr !== 5'h00 || bus.sid_data !== 8'h00) begin
         $display("FAIL reset_write_bus: got we=%b addr=%h data=%h expected 00 00 00",
                  bus.sid_we, bus.sid_addr, bus.sid_data);
         n_fail++;
      end
      n_checks++;
      if (bus.rom_index !== 8'd0 || bus.rom_read_en !== 1'b0 || bus.sid_ce_1m !== 1'b0) begin
         $display("FAIL reset_rom_ce: got index=%0d read_en=%b ce=%b expected 0 0 0",
                  bus.rom_index, bus.rom_read_en, bus.sid_ce_1m);
         n_fail++;
      end
      n_checks++;
      if (bus.playing !== 1'b0 || bus.halted !== 1'b0) begin
         $display("FAIL reset_status: got playing=%b halted=%b expected 0 0",
                  bus.playing, bus.halted);
         n_fail++;
      end
   endtask

   // Tick, reset release timing and a single write to SID 1.
   task automatic test_tick_and_write();
      logic [1:0] exp_we;
      clear_rom();
      rom_mem[0] = {2'd1, 5'h18, 8'h0F};
      do_reset();
      bus.run = 1'b1;
      for (int k = 0; k <= 40; k++) begin
         run_to(k);
         n_checks++;
         if (bus.sid_ce_1m !== (k >= 12 && k % 12 == 0)) begin
            $display("FAIL tick_ce c%0d: got %b", k, bus.sid_ce_1m);
            n_fail++;
         end
         n_checks++;
         if (bus.sid_reset !== (k < 12)) begin
            $display("FAIL tick_sid_reset c%0d: got %b expected %b", k, bus.sid_reset, k < 12);
            n_fail++;
         end
         n_checks++;
         if (bus.dac_reset !== (k < 36)) begin
            $display("FAIL tick_dac_reset c%0d: got %b expected %b", k, bus.dac_reset, k < 36);
            n_fail++;
         end
         n_checks++;
         if (bus.playing !== (k >= 14)) begin
            $display("FAIL tick_playing c%0d: got %b expected %b", k, bus.playing, k >= 14);
            n_fail++;
         end
         n_checks++;
         if (bus.rom_read_en !== (k == 24 || k == 36)) begin
            $display("FAIL tick_read_en c%0d: got %b", k, bus.rom_read_en);
            n_fail++;
         end
         exp_we = (k >= 26 && k <= 36) ? 2'b10 : 2'b00;
         n_checks++;
         if (bus.sid_we !== exp_we) begin
            $display("FAIL write_we c%0d: got %b expected %b", k, bus.sid_we, exp_we);
            n_fail++;
         end
         if (k == 26) begin
            n_checks++;
            if (bus.sid_addr !== 5'h18 || bus.sid_data !== 8'h0F) begin
               $display("FAIL write_addr_data: got %h/%h expected 18/0f", bus.sid_addr,
                        bus.sid_data);
               n_fail++;
            end
         end
         if (k == 36) begin
            n_checks++;
            if (bus.rom_index !== 8'd1) begin
               $display("FAIL write_index: got %0d expected 1", bus.rom_index);
               n_fail++;
            end
         end
      end
   endtask

   // DELAY 4 at ROM[0]: next fetch five ticks later.
   task automatic test_delay();
      logic [1:0] exp_we;
      clear_rom();
      rom_mem[0] = {2'd0, 5'h1F, 8'd4};
      rom_mem[1] = {2'd0, 5'h05, 8'hAA};
      do_reset();
      bus.run = 1'b1;
      for (int k = 24; k <= 97; k++) begin
         run_to(k);
         n_checks++;
         if (bus.rom_read_en !== (k == 24 || k == 84 || k == 96)) begin
            $display("FAIL delay_read_en c%0d: got %b", k, bus.rom_read_en);
            n_fail++;
         end
         exp_we = (k >= 86 && k <= 96) ? 2'b01 : 2'b00;
         n_checks++;
         if (bus.sid_we !== exp_we) begin
            $display("FAIL delay_we c%0d: got %b expected %b", k, bus.sid_we, exp_we);
            n_fail++;
         end
         if (k == 84) begin
            n_checks++;
            if (bus.rom_index !== 8'd1) begin
               $display("FAIL delay_index: got %0d expected 1", bus.rom_index);
               n_fail++;
            end
         end
         if (k == 86) begin
            n_checks++;
            if (bus.sid_addr !== 5'h05 || bus.sid_data !== 8'hAA) begin
               $display("FAIL delay_addr_data: got %h/%h expected 05/aa", bus.sid_addr,
                        bus.sid_data);
               n_fail++;
            end
         end
      end
   endtask

   // Select 3 with two SIDs: dropped, index still advances.
   task automatic test_invalid_sel();
      clear_rom();
      rom_mem[0] = {2'd3, 5'h04, 8'h55};
      do_reset();
      bus.run = 1'b1;
      for (int k = 24; k <= 40; k++) begin
         run_to(k);
         n_checks++;
         if (bus.sid_we !== 2'b00) begin
            $display("FAIL badsel_we c%0d: got %b expected 00", k, bus.sid_we);
            n_fail++;
         end
      end
      n_checks++;
      if (bus.rom_index !== 8'd1) begin
         $display("FAIL badsel_index: got %0d expected 1", bus.rom_index);
         n_fail++;
      end
   endtask

   task automatic test_end();
      clear_rom();
      rom_mem[0] = {2'd0, 5'h01, 8'h11};
      rom_mem[1] = {2'd1, 5'h02, 8'h22};
      rom_mem[2] = {2'd0, 5'h1E, 8'h00};
      do_reset();
      bus.run = 1'b1;
`ifdef SID_PLAYER_LOOP_EN
      run_to(60);
      n_checks++;
      if (bus.rom_read_en !== 1'b1 || bus.rom_index !== 8'd0) begin
         $display("FAIL loop_refetch: got read_en=%b index=%0d expected 1 0",
                  bus.rom_read_en, bus.rom_index);
         n_fail++;
      end
      run_to(62);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.sid_addr !== 5'h01 || bus.sid_data !== 8'h11) begin
         $display("FAIL loop_write1: got we=%b addr=%h data=%h expected 01 01 11",
                  bus.sid_we, bus.sid_addr, bus.sid_data);
         n_fail++;
      end
      run_to(98);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.rom_index !== 8'd0) begin
         $display("FAIL loop_write2: got we=%b index=%0d expected 01 0", bus.sid_we,
                  bus.rom_index);
         n_fail++;
      end
      run_to(100);
      n_checks++;
      if (bus.halted !== 1'b0 || bus.playing !== 1'b1) begin
         $display("FAIL loop_status: got halted=%b playing=%b expected 0 1", bus.halted,
                  bus.playing);
         n_fail++;
      end
`else
      for (int k = 49; k <= 100; k++) begin
         run_to(k);
         n_checks++;
         if (bus.rom_read_en !== 1'b0) begin
            $display("FAIL halt_read_en c%0d: got %b expected 0", k, bus.rom_read_en);
            n_fail++;
         end
         if (k == 51 || k == 100) begin
            n_checks++;
            if (bus.halted !== 1'b1 || bus.playing !== 1'b0) begin
               $display("FAIL halt_status c%0d: got halted=%b playing=%b expected 1 0", k,
                        bus.halted, bus.playing);
               n_fail++;
            end
         end
      end
      n_checks++;
      if (bus.rom_index !== 8'd2) begin
         $display("FAIL halt_index: got %0d expected 2", bus.rom_index);
         n_fail++;
      end
`endif
   endtask

   // run dropped mid-tick after the fifth fetch, then restored.
   task automatic test_pause_resume();
      clear_rom();
      for (int i = 0; i < 10; i++) rom_mem[i] = {2'd0, 5'(i), 8'(i)};
      do_reset();
      bus.run = 1'b1;
      run_to(73);
      bus.run = 1'b0;
      run_to(80);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.sid_addr !== 5'h04) begin
         $display("FAIL pause_inflight: got we=%b addr=%h expected 01 04", bus.sid_we,
                  bus.sid_addr);
         n_fail++;
      end
      for (int k = 84; k <= 150; k++) begin
         run_to(k);
         n_checks++;
         if (bus.rom_read_en !== 1'b0 || bus.rom_index !== 8'd5) begin
            $display("FAIL pause_hold c%0d: got read_en=%b index=%0d expected 0 5", k,
                     bus.rom_read_en, bus.rom_index);
            n_fail++;
         end
         if (k == 86) begin
            n_checks++;
            if (bus.playing !== 1'b0) begin
               $display("FAIL pause_playing: got %b expected 0", bus.playing);
               n_fail++;
            end
         end
      end
      bus.run = 1'b1;
      run_to(168);
      n_checks++;
      if (bus.rom_read_en !== 1'b1 || bus.rom_index !== 8'd5) begin
         $display("FAIL resume_fetch: got read_en=%b index=%0d expected 1 5", bus.rom_read_en,
                  bus.rom_index);
         n_fail++;
      end
      run_to(170);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.sid_addr !== 5'h05 || bus.sid_data !== 8'h05) begin
         $display("FAIL resume_write: got we=%b addr=%h data=%h expected 01 05 05", bus.sid_we,
                  bus.sid_addr, bus.sid_data);
         n_fail++;
      end
      run_to(180);
      n_checks++;
      if (bus.rom_index !== 8'd6) begin
         $display("FAIL resume_index: got %0d expected 6", bus.rom_index);
         n_fail++;
      end
   endtask

   // Two writes in consecutive ticks, then asynchronous reset during the second.
   task automatic test_back_to_back();
      clear_rom();
      rom_mem[0] = {2'd1, 5'h18, 8'h0F};
      rom_mem[1] = {2'd0, 5'h03, 8'h33};
      do_reset();
      bus.run = 1'b1;
      run_to(36);
      n_checks++;
      if (bus.sid_we !== 2'b10) begin
         $display("FAIL b2b_first: got %b expected 10", bus.sid_we);
         n_fail++;
      end
      run_to(37);
      n_checks++;
      if (bus.sid_we !== 2'b00) begin
         $display("FAIL b2b_gap: got %b expected 00", bus.sid_we);
         n_fail++;
      end
      run_to(38);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.sid_addr !== 5'h03 || bus.sid_data !== 8'h33) begin
         $display("FAIL b2b_second: got we=%b addr=%h data=%h expected 01 03 33", bus.sid_we,
                  bus.sid_addr, bus.sid_data);
         n_fail++;
      end
      run_to(40);
      n_checks++;
      if (bus.sid_we !== 2'b01 || bus.rom_index !== 8'd1) begin
         $display("FAIL midwrite_pre: got we=%b index=%0d expected 01 1", bus.sid_we,
                  bus.rom_index);
         n_fail++;
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.sid_we !== 2'b00 || bus.rom_index !== 8'd0 || bus.sid_reset !== 1'b1) begin
         $display("FAIL midwrite_reset: got we=%b index=%0d sid_reset=%b expected 00 0 1",
                  bus.sid_we, bus.rom_index, bus.sid_reset);
         n_fail++;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      bus.run  = 1'b0;
      clear_rom();
      test_reset();
      test_tick_and_write();
      test_delay();
      test_invalid_sel();
      test_end();
      test_pause_resume();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
